hswish_stream: RTL

Streaming, multi-lane activation unit for the MobileViT accelerator. It applies a per-beat selectable piecewise-linear activation to `LANES` packed signed fixed-point elements: bypass, ReLU, ReLU6, hard-sigmoid or hard-swish. An optional left-shift requantisation follows, with saturation. The block sits between the conv/MAC requantiser output and the feature-map writeback. It is a 3-stage valid/ready pipeline with saturation and error statistics.

---
 rtl/hswish_stream_pkg.sv | 29 ++
 rtl/hswish_lane.sv | 137 +++++++++++++
 rtl/hswish_stream.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hswish_stream_pkg.sv
// Shared types and Q-format constants for the streaming activation unit.
// Imported by the lane datapath and the stream top level.
package act_pkg;

  localparam int SAT_W = 16;

  typedef enum logic [2:0] {
    BYPASS = 3'd0,
    RELU   = 3'd1,
    RELU6  = 3'd2,
    HSIG   = 3'd3,
    HSWISH = 3'd4
  } act_mode_e;

  typedef enum logic [1:0] {
    SEL_PASS,
    SEL_DIV6,
    SEL_DIVQ
  } div_sel_e;

  function automatic int three_q(input int frac);
    return 3 << frac;
  endfunction

  function automatic int six_q(input int frac);
    return 6 << frac;
  endfunction

endpackage

// File: rtl/hswish_lane.sv
// One element's activation datapath: S1 offset/clamp, S2 select/product,
// S3 floor-divide, left shift and saturation.
module hswish_lane
  import act_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld1_i,
  input  logic                    ld2_i,
  input  logic                    ld3_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic [2:0]              mode_i,
  input  logic [1:0]              lshift_i,
  output logic [WIDTH-1:0]        y_o,
  output logic                    sat_o
);

  localparam int RW = WIDTH + 2;
  localparam int NW = 2*WIDTH + 2;
  localparam int ZW = NW + 3;

  localparam logic signed [RW-1:0] THREE_R = RW'(three_q(FRAC));
  localparam logic signed [RW-1:0] SIX_R   = RW'(six_q(FRAC));
  localparam logic signed [NW-1:0] THREE_N = NW'(three_q(FRAC));
  localparam logic signed [NW-1:0] SIX_N   = NW'(six_q(FRAC));
  localparam logic signed [NW-1:0] DIV6_N  = NW'(6);
  localparam logic signed [NW-1:0] SIXQ_N  = NW'(six_q(FRAC));
  localparam logic signed [ZW-1:0] ZMAX    = ZW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ZW-1:0] ZMIN    = ~ZMAX;

  logic signed [RW-1:0]    xr, rsum, r_d, r1_q;
  logic signed [WIDTH-1:0] x1_q;

  assign xr   = RW'(x_i);
  assign rsum = xr + THREE_R;

  always_comb begin
    r_d = rsum;
    if (rsum < 0)
      r_d = '0;
    else if (rsum > SIX_R)
      r_d = SIX_R;
  end

  logic signed [NW-1:0] xn, rn, prod, n_d, n2_q;
  div_sel_e             sel_d, sel2_q;

  assign xn   = NW'(x1_q);
  assign rn   = NW'(r1_q);
  assign prod = xn * rn;

  always_comb begin
    n_d   = xn;
    sel_d = SEL_PASS;
    case (mode_i)
      RELU: begin
        if (xn < 0) n_d = '0;
      end
      RELU6: begin
        if (xn < 0)
          n_d = '0;
        else if (xn > SIX_N)
          n_d = SIX_N;
      end
      HSIG: begin
        n_d   = rn + NW'(3);
        sel_d = SEL_DIV6;
      end
      HSWISH: begin
        n_d   = prod + THREE_N;
        sel_d = SEL_DIVQ;
      end
      default: ;
    endcase
  end

  // Signed '/' truncates toward zero; step negatives with a remainder down.
  logic signed [NW-1:0] q6, qq, rq, qf, y;
  logic signed [ZW-1:0] z;
  logic [WIDTH-1:0]     y_d;
  logic                 sat_d;

  assign q6 = n2_q / DIV6_N;
  assign qq = n2_q / SIXQ_N;
  assign rq = n2_q % SIXQ_N;
  assign qf = (n2_q[NW-1] && rq != '0) ? qq - NW'(1) : qq;

  always_comb begin
    unique case (sel2_q)
      SEL_DIV6: y = q6;
      SEL_DIVQ: y = qf;
      default:  y = n2_q;
    endcase
  end

  assign z = ZW'(y) <<< lshift_i;

  always_comb begin
    y_d   = z[WIDTH-1:0];
    sat_d = 1'b0;
    if (z > ZMAX) begin
      y_d   = ZMAX[WIDTH-1:0];
      sat_d = 1'b1;
    end else if (z < ZMIN) begin
      y_d   = ZMIN[WIDTH-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_q   <= '0;
      r1_q   <= '0;
      n2_q   <= '0;
      sel2_q <= SEL_PASS;
      y_o    <= '0;
      sat_o  <= 1'b0;
    end else begin
      if (ld1_i) begin
        x1_q <= x_i;
        r1_q <= r_d;
      end
      if (ld2_i) begin
        n2_q   <= n_d;
        sel2_q <= sel_d;
      end
      if (ld3_i) begin
        y_o   <= y_d;
        sat_o <= sat_d;
      end
    end
  end

endmodule

// File: rtl/hswish_stream.sv
// Three-stage valid/ready activation stream: valid chain, per-beat
// sideband, saturation counter and reserved-mode error flag.
module hswish_stream
  import act_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [2:0]               in_mode,
  input  logic [1:0]               in_lshift,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     out_last,
  input  logic                     clr_stats,
  output logic [SAT_W-1:0]         sat_cnt,
  output logic                     err_mode
);

  if (FRAC < 0 || FRAC > WIDTH - 4) begin : g_bad_frac
    $error("hswish_stream: FRAC must lie in 0..WIDTH-4");
  end

  logic v1_q, v2_q, v3_q;
  logic en1, en2, en3;
  logic in_hs, out_hs, ld2, ld3;

  assign en3       = !v3_q || out_ready;
  assign en2       = !v2_q || en3;
  assign en1       = !v1_q || en2;
  assign in_ready  = en1;
  assign in_hs     = in_valid && en1;
  assign out_hs    = v3_q && out_ready;
  assign ld2       = en2 && v1_q;
  assign ld3       = en3 && v2_q;
  assign out_valid = v3_q;

  logic [2:0] mode1_q;
  logic [1:0] lshift1_q, lshift2_q;
  logic       last1_q, last2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      mode1_q   <= '0;
      lshift1_q <= '0;
      lshift2_q <= '0;
      last1_q   <= 1'b0;
      last2_q   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (en1) v1_q <= in_valid;
      if (en2) v2_q <= v1_q;
      if (en3) v3_q <= v2_q;
      if (in_hs) begin
        mode1_q   <= in_mode;
        lshift1_q <= in_lshift;
        last1_q   <= in_last;
      end
      if (ld2) begin
        lshift2_q <= lshift1_q;
        last2_q   <= last1_q;
      end
      if (ld3) out_last <= last2_q;
    end
  end

  logic [LANES-1:0] sat_v;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    hswish_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ld1_i    (in_hs),
      .ld2_i    (ld2),
      .ld3_i    (ld3),
      .x_i      (in_data[i*WIDTH +: WIDTH]),
      .mode_i   (mode1_q),
      .lshift_i (lshift2_q),
      .y_o      (out_data[i*WIDTH +: WIDTH]),
      .sat_o    (sat_v[i])
    );
  end

  logic [SAT_W-1:0] sat_cnt_d, sat_cnt_q;
  logic             err_d, err_q;

  // Clear beats a coincident increment; a coincident error set beats clear.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    err_d     = err_q;
    if (clr_stats)
      sat_cnt_d = '0;
    else if (out_hs && |sat_v && sat_cnt_q != '1)
      sat_cnt_d = sat_cnt_q + 1'b1;
    if (in_hs && in_mode >= 3'd5)
      err_d = 1'b1;
    else if (clr_stats)
      err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      err_q     <= err_d;
    end
  end

  assign sat_cnt  = sat_cnt_q;
  assign err_mode = err_q;

endmodule
